// File: rtl/spi_serdes_burst.sv
// SPI slave serialiser/deserialiser for multi-word bursts under one slave-select,
// with a single-entry transmit holding buffer and underrun/frame event pulses.
module spi_serdes_burst #(
  parameter int PACKET_WIDTH = 8,
  parameter int CPOL = 0,
  parameter int CPHA = 0,
  parameter int MSB_FIRST = 1,
  parameter int SYNC_STAGES = 2,
  parameter logic [PACKET_WIDTH-1:0] UNDERRUN_FILL = {PACKET_WIDTH{1'b1}}
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    spi_SCLK,
  input  logic                    spi_SSEL,
  input  logic                    spi_MOSI,
  output logic                    spi_MISO,
  input  logic [PACKET_WIDTH-1:0] outPacket,
  input  logic                    outValid,
  output logic                    outReady,
  output logic [PACKET_WIDTH-1:0] inPacket,
  output logic                    dataReady,
  output logic [15:0]             wordIndex,
  output logic                    busy,
  output logic                    underrun,
  output logic                    frameEnd
);

  localparam int CW = $clog2(PACKET_WIDTH + 1);
  localparam logic IDLE_LVL = (CPOL != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] LAST_BIT = CW'(PACKET_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  function automatic logic first_bit(input logic [PACKET_WIDTH-1:0] w);
    if (MSB_FIRST != 0) first_bit = w[PACKET_WIDTH-1];
    else                first_bit = w[0];
  endfunction

  function automatic logic [PACKET_WIDTH-1:0] tx_shift(input logic [PACKET_WIDTH-1:0] w);
    if (MSB_FIRST != 0) tx_shift = {w[PACKET_WIDTH-2:0], 1'b0};
    else                tx_shift = {1'b0, w[PACKET_WIDTH-1:1]};
  endfunction

  function automatic logic [PACKET_WIDTH-1:0] rx_shift(input logic [PACKET_WIDTH-1:0] w,
                                                       input logic b);
    if (MSB_FIRST != 0) rx_shift = {w[PACKET_WIDTH-2:0], b};
    else                rx_shift = {b, w[PACKET_WIDTH-1:1]};
  endfunction

  logic [SYNC_STAGES-1:0]  sclk_sync_r, ssel_sync_r, mosi_sync_r;
  logic                    sclk_prev_r, ssel_prev_r;
  state_t                  state_r, state_next_s;
  logic [PACKET_WIDTH-1:0] hold_r, tx_r, rx_r, in_packet_r;
  logic                    full_r, miso_r, data_ready_r, underrun_r, frame_end_r;
  logic [CW-1:0]           bit_cnt_r;
  logic [15:0]             word_index_r;

  logic sclk_s, ssel_s, mosi_s, lead_s, trail_s, ssel_fall_s, ssel_rise_s;
  logic sample_edge_s, shift_edge_s;
  logic busy_s, start_s, sample_s, load_s, shift_s, abort_s, ready_s, write_s;
  logic [PACKET_WIDTH-1:0] load_word_s, tx_next_s, rx_next_s;

  // Synchronisers; SSEL starts low so a select already asserted at reset release never starts a frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_r <= {SYNC_STAGES{IDLE_LVL}};
      ssel_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= IDLE_LVL;
      ssel_prev_r <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_SCLK};
      ssel_sync_r <= {ssel_sync_r[SYNC_STAGES-2:0], spi_SSEL};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_MOSI};
      sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
      ssel_prev_r <= ssel_sync_r[SYNC_STAGES-1];
    end
  end

  assign sclk_s        = sclk_sync_r[SYNC_STAGES-1];
  assign ssel_s        = ssel_sync_r[SYNC_STAGES-1];
  assign mosi_s        = mosi_sync_r[SYNC_STAGES-1];
  assign lead_s        = (sclk_s != sclk_prev_r) && (sclk_s != IDLE_LVL);
  assign trail_s       = (sclk_s != sclk_prev_r) && (sclk_s == IDLE_LVL);
  assign ssel_fall_s   = ssel_prev_r && !ssel_s;
  assign ssel_rise_s   = !ssel_prev_r && ssel_s;
  assign sample_edge_s = (CPHA != 0) ? trail_s : lead_s;
  assign shift_edge_s  = (CPHA != 0) ? lead_s : trail_s;

  // Frame state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Frame next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (ssel_fall_s) state_next_s = ACTIVE; else state_next_s = IDLE;
      ACTIVE:  if (ssel_rise_s) state_next_s = IDLE;   else state_next_s = ACTIVE;
      default: state_next_s = IDLE;
    endcase
  end

  // Per-state event strobes; a bit counter of zero on a shift edge marks a word boundary
  always_comb begin
    busy_s   = 1'b0;
    start_s  = 1'b0;
    sample_s = 1'b0;
    load_s   = 1'b0;
    shift_s  = 1'b0;
    abort_s  = 1'b0;
    case (state_r)
      IDLE: begin
        start_s = ssel_fall_s;
        load_s  = ssel_fall_s && (CPHA == 0);
      end
      ACTIVE: begin
        busy_s   = 1'b1;
        abort_s  = ssel_rise_s;
        sample_s = sample_edge_s;
        load_s   = shift_edge_s && (bit_cnt_r == {CW{1'b0}}) && !ssel_rise_s;
        shift_s  = shift_edge_s && (bit_cnt_r != {CW{1'b0}}) && !ssel_rise_s;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign ready_s     = !full_r || load_s;
  assign write_s     = outValid && ready_s;
  assign load_word_s = full_r ? hold_r : UNDERRUN_FILL;
  assign tx_next_s   = tx_shift(tx_r);
  assign rx_next_s   = rx_shift(rx_r, mosi_s);

  // Holding buffer: a load and a write in the same cycle hand over the old word and keep the new one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_r <= {PACKET_WIDTH{1'b0}};
      full_r <= 1'b0;
    end else begin
      if (write_s) hold_r <= outPacket;
      if (write_s)     full_r <= 1'b1;
      else if (load_s) full_r <= 1'b0;
    end
  end

  // Transmit shifter; MISO is registered and takes the first bit straight from the load path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_r   <= {PACKET_WIDTH{1'b0}};
      miso_r <= 1'b0;
    end else if (load_s) begin
      tx_r   <= load_word_s;
      miso_r <= first_bit(load_word_s);
    end else if (shift_s) begin
      tx_r   <= tx_next_s;
      miso_r <= first_bit(tx_next_s);
    end else if (abort_s) begin
      tx_r   <= {PACKET_WIDTH{1'b0}};
      miso_r <= 1'b0;
    end
  end

  // Receive shifter and event pulses; a completing sample still lands when the frame aborts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_r         <= {PACKET_WIDTH{1'b0}};
      bit_cnt_r    <= {CW{1'b0}};
      in_packet_r  <= {PACKET_WIDTH{1'b0}};
      data_ready_r <= 1'b0;
      word_index_r <= 16'd0;
      underrun_r   <= 1'b0;
      frame_end_r  <= 1'b0;
    end else begin
      data_ready_r <= 1'b0;
      underrun_r   <= load_s && !full_r;
      frame_end_r  <= abort_s;
      if (start_s) begin
        word_index_r <= 16'd0;
        bit_cnt_r    <= {CW{1'b0}};
        rx_r         <= {PACKET_WIDTH{1'b0}};
      end else if (sample_s) begin
        if (bit_cnt_r == LAST_BIT) begin
          in_packet_r  <= rx_next_s;
          data_ready_r <= 1'b1;
          bit_cnt_r    <= {CW{1'b0}};
          if (word_index_r != 16'hFFFF) word_index_r <= word_index_r + 16'd1;
        end else begin
          rx_r      <= rx_next_s;
          bit_cnt_r <= bit_cnt_r + CW'(1);
        end
      end
      if (abort_s) begin
        rx_r      <= {PACKET_WIDTH{1'b0}};
        bit_cnt_r <= {CW{1'b0}};
      end
    end
  end

  assign spi_MISO  = miso_r;
  assign outReady  = ready_s;
  assign inPacket  = in_packet_r;
  assign dataReady = data_ready_r;
  assign wordIndex = word_index_r;
  assign busy      = busy_s;
  assign underrun  = underrun_r;
  assign frameEnd  = frame_end_r;

endmodule

// File: tb/tb_spi_serdes_burst.sv
// Bench for spi_serdes_burst: four 8-bit MSB-first instances (SPI modes 0..3) and one
// 12-bit LSB-first mode-0 instance, driven by a bit-level SPI master task.
module tb_spi_serdes_burst;

  logic clk, reset_n;
  logic sclk [5], ssel [5], mosi [5], ov [5];
  logic miso [5], ordy [5], drdy [5], und [5], fe [5], bsy [5];
  logic [15:0] widx [5];
  logic [7:0]  op8 [4], inp8 [4];
  logic [11:0] op12, inp12;

  int n_checks = 0, n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_serdes_burst #(.PACKET_WIDTH(8), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1),
                       .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .spi_SCLK(sclk[g]), .spi_SSEL(ssel[g]),
      .spi_MOSI(mosi[g]), .spi_MISO(miso[g]), .outPacket(op8[g]), .outValid(ov[g]),
      .outReady(ordy[g]), .inPacket(inp8[g]), .dataReady(drdy[g]), .wordIndex(widx[g]),
      .busy(bsy[g]), .underrun(und[g]), .frameEnd(fe[g]));
  end

  spi_serdes_burst #(.PACKET_WIDTH(12), .CPOL(0), .CPHA(0), .MSB_FIRST(0),
                     .SYNC_STAGES(2)) dut_lsb12 (
    .clk(clk), .reset_n(reset_n), .spi_SCLK(sclk[4]), .spi_SSEL(ssel[4]),
    .spi_MOSI(mosi[4]), .spi_MISO(miso[4]), .outPacket(op12), .outValid(ov[4]),
    .outReady(ordy[4]), .inPacket(inp12), .dataReady(drdy[4]), .wordIndex(widx[4]),
    .busy(bsy[4]), .underrun(und[4]), .frameEnd(fe[4]));

  function automatic int wid(input int d);     return (d == 4) ? 12 : 8; endfunction
  function automatic int cpol_of(input int d); return (d == 4) ? 0 : d / 2; endfunction
  function automatic int cpha_of(input int d); return (d == 4) ? 0 : d % 2; endfunction
  function automatic logic [15:0] wmask(input int d);
    return (d == 4) ? 16'h0FFF : 16'h00FF;
  endfunction
  function automatic logic [15:0] get_inp(input int d);
    return (d == 4) ? {4'h0, inp12} : {8'h00, inp8[d]};
  endfunction

  task automatic set_op(input int d, input logic [15:0] w);
    if (d == 4) op12 = w[11:0];
    else        op8[d] = w[7:0];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Current frame stimulus and observations
  int f_d, f_bits, f_nprov, f_rst_bit;
  logic [3:0][15:0] f_mw, f_pw, o_rx, o_miso;
  int o_drdy, o_und, o_fe, o_busy, feed_i;
  logic rdy_seen;

  task automatic step();
    @(posedge clk);
    #1;
    if (ov[f_d] && rdy_seen) begin
      feed_i++;
      ov[f_d] = 1'b0;
    end
    if (!ov[f_d] && feed_i < f_nprov) begin
      ov[f_d] = 1'b1;
      set_op(f_d, f_pw[feed_i]);
    end
    if (drdy[f_d]) begin
      if (o_drdy < 4) o_rx[o_drdy] = get_inp(f_d);
      o_drdy++;
    end
    if (und[f_d]) o_und++;
    if (fe[f_d])  o_fe++;
    if (bsy[f_d]) o_busy = 1;
    rdy_seen = ordy[f_d];
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  function automatic logic mbit(input int i);
    int w, wd, b;
    logic [15:0] word;
    w = wid(f_d);
    wd = i / w;
    b = i % w;
    if (wd > 3) return 1'b0;
    word = f_mw[wd];
    return (f_d == 4) ? word[b] : word[w - 1 - b];
  endfunction

  task automatic capture(input int i);
    int w, wd, b;
    logic [15:0] t;
    w = wid(f_d);
    wd = i / w;
    b = i % w;
    if (wd <= 3) begin
      t = o_miso[wd];
      if (f_d == 4) t[b] = miso[f_d];
      else          t[w - 1 - b] = miso[f_d];
      o_miso[wd] = t;
    end
  endtask

  task automatic chk_reset(input int d, input string tag);
    chk($sformatf("%s_miso%0d", tag, d),  {31'd0, miso[d]}, 32'd0);
    chk($sformatf("%s_ready%0d", tag, d), {31'd0, ordy[d]}, 32'd1);
    chk($sformatf("%s_drdy%0d", tag, d),  {31'd0, drdy[d]}, 32'd0);
    chk($sformatf("%s_busy%0d", tag, d),  {31'd0, bsy[d]},  32'd0);
    chk($sformatf("%s_und%0d", tag, d),   {31'd0, und[d]},  32'd0);
    chk($sformatf("%s_fe%0d", tag, d),    {31'd0, fe[d]},   32'd0);
    chk($sformatf("%s_widx%0d", tag, d),  {16'd0, widx[d]}, 32'd0);
    chk($sformatf("%s_inp%0d", tag, d),   {16'd0, get_inp(d)}, 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk_reset(f_d, "midreset");
    step();
    step();
    reset_n = 1'b1;
    o_busy = 0;
  endtask

  // SPI master: full SCLK cycles, data changed on the non-sampling edge
  task automatic run_frame();
    int cpol, cpha;
    cpol = cpol_of(f_d);
    cpha = cpha_of(f_d);
    o_drdy = 0; o_und = 0; o_fe = 0; o_busy = 0; feed_i = 0;
    o_rx = '0; o_miso = '0;
    ov[f_d] = 1'b0;
    rdy_seen = ordy[f_d];
    ssel[f_d] = 1'b1;
    sclk[f_d] = (cpol != 0);
    wait_cycles(8);
    ssel[f_d] = 1'b0;
    if (cpha == 0) mosi[f_d] = mbit(0);
    wait_cycles(5);
    for (int i = 0; i < f_bits; i++) begin
      if (i == f_rst_bit) do_reset();
      sclk[f_d] = (cpol == 0);
      if (cpha == 0) capture(i);
      else           mosi[f_d] = mbit(i);
      wait_cycles(5);
      sclk[f_d] = (cpol != 0);
      if (cpha != 0) capture(i);
      else           mosi[f_d] = mbit(i + 1);
      wait_cycles(5);
    end
    wait_cycles(5);
    ssel[f_d] = 1'b1;
    wait_cycles(10);
    ov[f_d] = 1'b0;
  endtask

  // Reference model: words completed, loads per frame and the word each load must carry
  function automatic int model_loads(input int d, input int bits);
    int w;
    w = wid(d);
    return (cpha_of(d) != 0) ? (bits + w - 1) / w : 1 + bits / w;
  endfunction

  task automatic check_frame(input string tag, input int e_drdy, input int e_und);
    int nfull;
    logic [15:0] m, exp_tx;
    m = wmask(f_d);
    nfull = f_bits / wid(f_d);
    chk({tag, "_drdy_count"}, o_drdy, e_drdy);
    chk({tag, "_underruns"}, o_und, e_und);
    chk({tag, "_frame_end"}, o_fe, 1);
    chk({tag, "_busy_seen"}, o_busy, 1);
    chk({tag, "_busy_end"}, {31'd0, bsy[f_d]}, 32'd0);
    chk({tag, "_ready_end"}, {31'd0, ordy[f_d]}, 32'd1);
    chk({tag, "_word_index"}, {16'd0, widx[f_d]}, nfull);
    for (int k = 0; k < nfull && k < 4; k++) begin
      exp_tx = (k < f_nprov) ? (f_pw[k] & m) : m;
      chk($sformatf("%s_rx%0d", tag, k), {16'd0, o_rx[k]}, {16'd0, f_mw[k] & m});
      chk($sformatf("%s_tx%0d", tag, k), {16'd0, o_miso[k]}, {16'd0, exp_tx});
    end
  endtask

  typedef struct packed {
    logic [2:0]       d;
    logic [7:0]       bits;
    logic [3:0][15:0] mw;
    logic [3:0][15:0] pw;
    logic [2:0]       nprov;
    logic [2:0]       e_drdy;
    logic [2:0]       e_und;
  } vec_t;

  function automatic vec_t mk(input int d, input int bits, input logic [15:0] m0,
                              input logic [15:0] m1, input logic [15:0] p0,
                              input logic [15:0] p1, input int nprov, input int e_drdy,
                              input int e_und);
    vec_t v;
    v.d = 3'(d); v.bits = 8'(bits);
    v.mw = {16'h0, 16'h0, m1, m0};
    v.pw = {16'h0, 16'h0, p1, p0};
    v.nprov = 3'(nprov); v.e_drdy = 3'(e_drdy); v.e_und = 3'(e_und);
    return v;
  endfunction

  localparam int NV = 9;
  vec_t tbl [NV];

  initial begin
    // Mode-0 frames end with one extra trailing-edge load, hence the extra underrun
    tbl[0] = mk(0, 16, 16'hab, 16'h15, 16'hff, 16'ha5, 2, 2, 1);
    tbl[1] = mk(1, 16, 16'hab, 16'h15, 16'hff, 16'ha5, 2, 2, 0);
    tbl[2] = mk(2, 16, 16'hab, 16'h15, 16'hff, 16'ha5, 2, 2, 1);
    tbl[3] = mk(3, 16, 16'hab, 16'h15, 16'hff, 16'ha5, 2, 2, 0);
    tbl[4] = mk(1, 16, 16'h3c, 16'hc3, 16'h5a, 16'h00, 1, 2, 1);
    tbl[5] = mk(0, 16, 16'h3c, 16'hc3, 16'h5a, 16'h00, 1, 2, 2);
    tbl[6] = mk(0, 13, 16'h96, 16'h69, 16'h12, 16'h34, 2, 1, 0);
    tbl[7] = mk(0, 8,  16'he7, 16'h00, 16'h7e, 16'h00, 1, 1, 1);
    tbl[8] = mk(4, 12, 16'h5a3, 16'h000, 16'h0f1, 16'h000, 1, 1, 1);

    reset_n = 1'b0;
    f_d = 0;
    for (int i = 0; i < 5; i++) begin
      sclk[i] = (cpol_of(i) != 0);
      ssel[i] = 1'b1;
      mosi[i] = 1'b0;
      ov[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) op8[i] = 8'h00;
    op12 = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 5; d++) chk_reset(d, "reset");
    reset_n = 1'b1;
    repeat (6) @(posedge clk);

    for (int k = 0; k < NV; k++) begin
      f_d = int'(tbl[k].d); f_bits = int'(tbl[k].bits);
      f_mw = tbl[k].mw; f_pw = tbl[k].pw;
      f_nprov = int'(tbl[k].nprov); f_rst_bit = -1;
      run_frame();
      check_frame($sformatf("vec%0d", k), int'(tbl[k].e_drdy), int'(tbl[k].e_und));
    end
    chk("lsb12_inpacket_held", {16'd0, get_inp(4)}, 32'h5a3);

    // Reset mid-word with SSEL held low: the rest of the frame must be ignored
    f_d = 0; f_bits = 16; f_nprov = 0; f_rst_bit = 3;
    f_mw = {16'h0, 16'h0, 16'h55, 16'hc9}; f_pw = '0;
    run_frame();
    chk("rstframe_drdy", o_drdy, 0);
    chk("rstframe_fe", o_fe, 0);
    chk("rstframe_busy", o_busy, 0);
    chk("rstframe_widx", {16'd0, widx[0]}, 32'd0);
    f_bits = 8; f_nprov = 1; f_rst_bit = -1;
    f_mw = {16'h0, 16'h0, 16'h0, 16'h81}; f_pw = {16'h0, 16'h0, 16'h0, 16'h3d};
    run_frame();
    check_frame("after_reset", 1, 1);

    // Randomised frames against the model
    for (int r = 0; r < 30; r++) begin
      int w, nfull, loads;
      f_d = int'($urandom_range(4, 0));
      w = wid(f_d);
      nfull = int'($urandom_range(3, 1));
      f_bits = nfull * w + (($urandom_range(2, 0) == 0) ? int'($urandom_range(w - 1, 1)) : 0);
      for (int k = 0; k < 4; k++) begin
        f_mw[k] = 16'($urandom);
        f_pw[k] = 16'($urandom);
      end
      loads = model_loads(f_d, f_bits);
      f_nprov = int'($urandom_range(loads, 0));
      f_rst_bit = -1;
      run_frame();
      check_frame($sformatf("rnd%0d_d%0d", r, f_d), nfull, loads - f_nprov);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
